// File: rtl/btb.sv
// Direct-mapped branch target buffer: registered lookup of hit/target by fetch PC,
// taken-branch write-back from execute, and a one-entry-per-cycle invalidate-all sweep.
module btb #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        lookup_en,
  input  logic [1:0]  flush,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        inv_req,
  output logic        btb_hit,
  output logic [31:0] btb_target,
  output logic        busy,
  output logic [15:0] hit_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [29:0]        tgt_mem [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             do_lookup;
  logic             upd_we;
  logic             unused_low_bits;

  assign rd_idx = PC[IDX_W+1:2];
  assign rd_tag = PC[31:IDX_W+2];
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = upd_pc[31:IDX_W+2];

  // Byte offsets carry no information for word-aligned fetch.
  assign unused_low_bits = ^{PC[1:0], upd_pc[1:0], upd_target[1:0]};

  assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign do_lookup = lookup_en && (flush == 2'b00) && (state == ST_IDLE);
  assign upd_we    = upd_en && upd_taken && (state == ST_IDLE);

  assign busy = (state == ST_SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ptr <= '0;
          if (inv_req) state <= ST_SWEEP;
        end
        ST_SWEEP: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Valid bits are the only state that must be cleared; tags/targets are gated by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (state == ST_SWEEP) begin
      valid[ptr] <= 1'b0;
    end else if (upd_we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= upd_target[31:2];
    end
  end

  // Reads sample the pre-edge array, so a same-cycle update is seen only next cycle.
  always_ff @(posedge clk) begin
    if (rst || !do_lookup) begin
      btb_hit    <= 1'b0;
      btb_target <= 32'h0;
    end else begin
      btb_hit    <= rd_hit;
      btb_target <= rd_hit ? {tgt_mem[rd_idx], 2'b00} : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= 16'h0;
    end else if (btb_hit && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'h1;
    end
  end

endmodule

// File: tb/tb_btb.sv
// Bench for btb: directed scenarios plus randomized traffic, every cycle compared
// against a table-level reference model of the BTB.
module tb_btb;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        lookup_en;
  logic [1:0]  flush;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        inv_req;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        busy;
  logic [15:0] hit_cnt;

  always #5 clk = ~clk;

  btb #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .PC(pc), .lookup_en(lookup_en), .flush(flush),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .inv_req(inv_req), .btb_hit(btb_hit), .btb_target(btb_target), .busy(busy),
    .hit_cnt(hit_cnt)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_sweep;
  int          m_swept;
  logic        m_hit;
  logic [31:0] m_target;
  int          m_cnt;
  logic [31:0] exp_q [$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model(input logic r, input logic [31:0] a, input logic le,
                       input logic [1:0] fl, input logic ue, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk, input logic inv);
    int idx;
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      m_sweep = 0; m_swept = 0; m_hit = 0; m_target = 0; m_cnt = 0;
    end else begin
      if (m_hit && m_cnt < 65535) m_cnt++;
      idx = (a >> 2) % ENTRIES;
      if (le && fl == 2'b00 && !m_sweep && m_valid[idx] && m_tag[idx] == (a >> (2 + IDX_W))) begin
        m_hit = 1; m_target = m_tgt[idx];
      end else begin
        m_hit = 0; m_target = 0;
      end
      if (m_sweep) begin
        // Entries below m_swept have been cleared so far.
        m_valid[m_swept] = 0;
        m_swept++;
        if (m_swept == ENTRIES) m_sweep = 0;
      end else begin
        if (ue && utk) begin
          idx = (upc >> 2) % ENTRIES;
          m_valid[idx] = 1;
          m_tag[idx]   = upc >> (2 + IDX_W);
          m_tgt[idx]   = utgt & 32'hFFFF_FFFC;
        end
        if (inv) begin m_sweep = 1; m_swept = 0; end
      end
    end
    exp_q.push_back(m_target);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [31:0] a, input logic le,
                      input logic [1:0] fl, input logic ue, input logic [31:0] upc,
                      input logic [31:0] utgt, input logic utk, input logic inv);
    logic [31:0] exp_t;
    rst = r; pc = a; lookup_en = le; flush = fl; upd_en = ue;
    upd_pc = upc; upd_target = utgt; upd_taken = utk; inv_req = inv;
    model(r, a, le, fl, ue, upc, utgt, utk, inv);
    @(posedge clk); #1;
    exp_t = exp_q.pop_front();
    chk("hit", {31'h0, btb_hit}, {31'h0, m_hit});
    chk("target", btb_target, exp_t);
    chk("busy", {31'h0, busy}, {31'h0, m_sweep});
    chk("hit_cnt", {16'h0, hit_cnt}, m_cnt[31:0]);
  endtask

  task automatic lookup(input logic [31:0] a);
    step(0, a, 1, 2'b00, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic update(input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
    step(0, 32'h0, 0, 2'b00, 1, upc, utgt, utk, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 32'h0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic fill_all;
    for (int i = 0; i < ENTRIES; i++) update(32'h1000 + i * 4, 32'h2000 + i * 16, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h03FF_FFFF, 32'h0012_3456};

  initial begin
    int busy_cycles;
    logic [31:0] a, u;

    // Reset
    do_reset(2);
    lookup(32'h0000_0040);
    chk("rst_hit", {31'h0, btb_hit}, 32'h0);
    chk("rst_tgt", btb_target, 32'h0);
    chk("rst_cnt", {16'h0, hit_cnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // Allocate and hit
    update(32'h0000_0040, 32'h0000_0100, 1);
    lookup(32'h0000_0040);
    chk("alloc_hit", {31'h0, btb_hit}, 32'h1);
    chk("alloc_tgt", btb_target, 32'h100);
    step(0, 32'h0, 0, 2'b00, 1, 32'h0000_0040, 32'h0000_0999, 0, 0);
    chk("alloc_cnt", {16'h0, hit_cnt}, 32'h1);
    lookup(32'h0000_0040);
    chk("nt_keep", btb_target, 32'h100);

    // Alias on index 0
    update(32'h0000_0040, 32'h0000_0100, 1);
    update(32'h0000_0080, 32'h0000_0203, 1);
    lookup(32'h0000_0040);
    chk("alias_old", {31'h0, btb_hit}, 32'h0);
    lookup(32'h0000_0080);
    chk("alias_new", btb_target, 32'h200);

    // Collision: same-cycle update and lookup reads old contents
    step(0, 32'h0000_0C04, 1, 2'b00, 1, 32'h0000_0C04, 32'h0000_3000, 1, 0);
    chk("coll_miss", {31'h0, btb_hit}, 32'h0);
    lookup(32'h0000_0C07);
    chk("coll_hit", btb_target, 32'h3000);
    step(0, 32'h0000_0C04, 1, 2'b01, 0, 32'h0, 32'h0, 0, 0);
    chk("flush_miss", {31'h0, btb_hit}, 32'h0);

    // Sweep: busy exactly ENTRIES cycles, updates dropped, table empty afterwards
    fill_all();
    step(0, 32'h0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 1);
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 40 && busy; i++) begin
      step(0, 32'h1000 + i * 4, 1, 2'b00, 1, 32'h1000 + (i % ENTRIES) * 4, 32'h5000, 1, i == 3);
      if (busy) busy_cycles++;
    end
    chk("sweep_len", busy_cycles, ENTRIES);
    for (int i = 0; i < ENTRIES; i++) lookup(32'h1000 + i * 4);
    chk("sweep_empty", {31'h0, btb_hit}, 32'h0);

    // Reset during sweep
    fill_all();
    step(0, 32'h0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    do_reset(1);
    chk("rst_sweep_busy", {31'h0, busy}, 32'h0);
    for (int i = ENTRIES - 1; i >= 0; i--) lookup(32'h1000 + i * 4);
    chk("rst_sweep_empty", {31'h0, btb_hit}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = (tags[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      u = (tags[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 199) == 0, a, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom_range(0, 1) == 1, u, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 59) == 0);
    end

    // Saturation of hit_cnt
    do_reset(1);
    update(32'h0000_0040, 32'h0000_0100, 1);
    for (int i = 0; i < 70000; i++) lookup(32'h0000_0040);
    chk("sat_cnt", {16'h0, hit_cnt}, 32'h0000_FFFF);
    lookup(32'h0000_0040);
    chk("sat_hold", {16'h0, hit_cnt}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
